// File: rtl/ntt_pkg.sv
// Shared constants, pipeline stage records and modular helpers for the NTT/INTT datapath.
package ntt_pkg;

  localparam int W   = 16;
  localparam int LAT = 4;

  localparam logic [W-1:0]   Q_DEFAULT  = W'(7681);
  localparam logic [2*W:0]   MU_DEFAULT = (2*W+1)'((64'd1 << (2*W)) / 64'd7681);

  // First-stage record: reduced sum on top, reduced difference on bot.
  typedef struct packed {
    logic         valid;
    logic         scale;
    logic [W-1:0] top;
    logic [W-1:0] bot;
  } stage_t;

  typedef struct packed {
    logic         valid;
    logic         scale;
    logic [W-1:0] top;
  } top_stage_t;

  // x/2 mod q for odd q: odd x borrows one q so the shift is exact.
  function automatic logic [W-1:0] mod_half(input logic [W-1:0] x, input logic [W-1:0] q);
    return x[0] ? W'(({1'b0, x} + {1'b0, q}) >> 1) : (x >> 1);
  endfunction

endpackage

// File: rtl/mod_mul_barrett.sv
// Three-stage pipelined Barrett modular multiplier with global enable and optional output halving.
module mod_mul_barrett
  import ntt_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic [W-1:0]   q,
  input  logic [2*W:0]   mu,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           half,
  output logic [W-1:0]   r
);

  logic [2*W-1:0] p2, p3;
  logic [W-1:0]   t3;
  logic           h2, h3;

  logic [4*W:0]   pm;
  logic [2*W-1:0] tq;
  logic [W+1:0]   r0, r1, r2;
  logic [W-1:0]   r_red;

  // NOTE: every signal gets a value on every path through always_comb, so no latch can be inferred.
  always_comb begin
    pm    = {{(2*W+1){1'b0}}, p2} * {{(2*W){1'b0}}, mu};
    tq    = {{W{1'b0}}, t3} * {{W{1'b0}}, q};
    // Quotient estimate undershoots by at most two, so r0 < 3q.
    r0    = (W+2)'(p3 - tq);
    r1    = (r0 >= {2'b00, q}) ? r0 - {2'b00, q} : r0;
    r2    = (r1 >= {2'b00, q}) ? r1 - {2'b00, q} : r1;
    r_red = W'(r2);
  end

  // NOTE: state is updated with non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p2 <= '0;
      h2 <= 1'b0;
      p3 <= '0;
      t3 <= '0;
      h3 <= 1'b0;
      r  <= '0;
    end else if (en) begin
      p2 <= {{W{1'b0}}, a} * {{W{1'b0}}, b};
      h2 <= half;
      p3 <= p2;
      t3 <= W'(pm >> (2*W));
      h3 <= h2;
      r  <= h3 ? mod_half(r_red, q) : r_red;
    end
  end

endmodule

// File: rtl/intt_pe_gs.sv
// Gentleman-Sande inverse-NTT butterfly PE: top'=(a+b) mod q, bot'=((a-b)*w) mod q, optional halving.
module intt_pe_gs
  import ntt_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic [W-1:0]   q,
  input  logic [2*W:0]   mu,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic           scale_i,
  input  logic [W-1:0]   data_top_i,
  input  logic [W-1:0]   data_bot_i,
  input  logic [W-1:0]   twiddle_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [W-1:0]   intt_top_o,
  output logic [W-1:0]   intt_bot_o
);

  logic       en;
  stage_t     s1;
  logic [W-1:0] s1_w;
  top_stage_t dl [LAT-2];
  top_stage_t tail;

  logic [W:0]   sum;
  logic [W-1:0] s_red, d_red;

  // The whole pipeline advances together; a stalled output freezes every stage.
  assign en         = !out_valid_o || out_ready_i;
  assign in_ready_o = en;

  always_comb begin
    sum   = {1'b0, data_top_i} + {1'b0, data_bot_i};
    s_red = (sum >= {1'b0, q}) ? W'(sum - {1'b0, q}) : W'(sum);
    d_red = (data_top_i >= data_bot_i) ? data_top_i - data_bot_i
                                       : data_top_i + q - data_bot_i;
    tail  = dl[LAT-3];
  end

  // NOTE: the delay-line array is reset like any other register so outputs read zero after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1          <= '0;
      s1_w        <= '0;
      for (int i = 0; i < LAT-2; i++) dl[i] <= '0;
      out_valid_o <= 1'b0;
      intt_top_o  <= '0;
    end else if (en) begin
      s1          <= '{valid: in_valid_i, scale: scale_i, top: s_red, bot: d_red};
      s1_w        <= twiddle_i;
      dl[0]       <= '{valid: s1.valid, scale: s1.scale, top: s1.top};
      for (int i = 1; i < LAT-2; i++) dl[i] <= dl[i-1];
      out_valid_o <= tail.valid;
      intt_top_o  <= tail.scale ? mod_half(tail.top, q) : tail.top;
    end
  end

  // Bottom path: S2 product, S3 quotient estimate, S4 correction and halving.
  mod_mul_barrett u_mul (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .q     (q),
    .mu    (mu),
    .a     (s1.bot),
    .b     (s1_w),
    .half  (s1.scale),
    .r     (intt_bot_o)
  );

endmodule

// File: tb/tb_intt_pe_gs.sv
// Self-checking bench for intt_pe_gs: arithmetic reference model, in-order scoreboard, directed vectors.
module tb_intt_pe_gs;
  import ntt_pkg::W;

  localparam longint QV        = 7681;
  localparam int     LAT_EDGES = 4;   // accepting edge through presenting edge, inclusive

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   q;
  logic [2*W:0]   mu;
  logic           in_valid_i, in_ready_o, scale_i;
  logic [W-1:0]   data_top_i, data_bot_i, twiddle_i;
  logic           out_valid_o, out_ready_i;
  logic [W-1:0]   intt_top_o, intt_bot_o;

  intt_pe_gs dut (
    .clk         (clk),
    .reset       (rst),
    .q           (q),
    .mu          (mu),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .scale_i     (scale_i),
    .data_top_i  (data_top_i),
    .data_bot_i  (data_bot_i),
    .twiddle_i   (twiddle_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .intt_top_o  (intt_top_o),
    .intt_bot_o  (intt_bot_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int edge_cnt = 0;
  int stall_cnt = 0;

  typedef struct {
    longint top;
    longint bot;
    int     acc_edge;
    int     acc_stall;
    bit     seen;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   cur;
  longint mt, mb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic longint half_mod(input longint x);
    return (x % 2 == 0) ? x / 2 : (x + QV) / 2;
  endfunction

  task automatic model(input longint a, input longint b, input longint w, input bit s,
                       output longint t, output longint bt);
    t  = (a + b) % QV;
    bt = ((((a - b) % QV) + QV) % QV * w) % QV;
    if (s) begin
      t  = half_mod(t);
      bt = half_mod(bt);
    end
  endtask

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Scoreboard: compare outputs against the queue head, log acceptances, count stall edges.
  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready_rule", in_ready_o, !out_valid_o || out_ready_i);
      if (out_valid_o) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", out_valid_o, 0);
        end else begin
          cur = exp_q[0];
          check("out_top", intt_top_o, cur.top);
          check("out_bot", intt_bot_o, cur.bot);
          if (!cur.seen) begin
            check("latency", edge_cnt - cur.acc_edge - (stall_cnt - cur.acc_stall) + 1, LAT_EDGES);
            cur.seen = 1'b1;
            exp_q[0] = cur;
          end
          if (out_ready_i) void'(exp_q.pop_front());
        end
      end
      if (in_valid_i && in_ready_o) begin
        model(longint'(data_top_i), longint'(data_bot_i), longint'(twiddle_i), scale_i, mt, mb);
        exp_q.push_back('{top: mt, bot: mb, acc_edge: edge_cnt + 1, acc_stall: stall_cnt, seen: 1'b0});
      end
      if (out_valid_o && !out_ready_i) stall_cnt++;
    end
  end

  // Holds in_valid_i high until the beat is taken; caller is at posedge+2.
  task automatic send(input longint a, input longint b, input longint w, input bit s);
    bit acc = 1'b0;
    in_valid_i = 1'b1;
    data_top_i = W'(a);
    data_bot_i = W'(b);
    twiddle_i  = W'(w);
    scale_i    = s;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready_o;
      @(posedge clk);
      #2;
    end
    if (!acc) check("send_timeout", in_ready_o, 1);
  endtask

  task automatic drain();
    in_valid_i = 1'b0;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    check("drain_empty", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #2;
  endtask

  // Directed vectors with hand-computed results for q=7681.
  longint dv_a   [7] = '{1,    0,    7680, 7680, 5,    5,    6};
  longint dv_b   [7] = '{0,    1,    7680, 0,    2,    2,    2};
  longint dv_w   [7] = '{1,    1,    5,    7680, 3,    3,    1};
  bit     dv_s   [7] = '{0,    0,    0,    0,    0,    1,    1};
  longint dv_top [7] = '{1,    1,    7679, 7680, 7,    3844, 4};
  longint dv_bot [7] = '{1,    7680, 0,    1,    9,    3845, 2};

  initial begin
    logic [W-1:0] snap_top, snap_bot;
    bit           snap_ok;
    int           sent;

    rst         = 1'b1;
    q           = W'(QV);
    mu          = (2*W+1)'(64'd4294967296 / 64'd7681);   // floor(2^32/7681) = 559167
    in_valid_i  = 1'b0;
    scale_i     = 1'b0;
    data_top_i  = '0;
    data_bot_i  = '0;
    twiddle_i   = '0;
    out_ready_i = 1'b1;

    #1;
    check("rst_out_valid", out_valid_o, 0);
    check("rst_top", intt_top_o, 0);
    check("rst_bot", intt_bot_o, 0);
    check("rst_in_ready", in_ready_o, 1);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Pin the reference model to the hand-computed table, then stream the table through the DUT.
    for (int i = 0; i < 7; i++) begin
      model(dv_a[i], dv_b[i], dv_w[i], dv_s[i], mt, mb);
      check($sformatf("pin_top_%0d", i), mt, dv_top[i]);
      check($sformatf("pin_bot_%0d", i), mb, dv_bot[i]);
    end
    for (int i = 0; i < 7; i++) send(dv_a[i], dv_b[i], dv_w[i], dv_s[i]);
    drain();

    // Back-to-back random stream.
    for (int i = 0; i < 8; i++)
      send($urandom_range(0, 7680), $urandom_range(0, 7680), $urandom_range(0, 7680), 1'($urandom_range(0, 1)));
    drain();

    // Continuous stream with out_ready_i low for three cycles while results are pending.
    sent    = 0;
    snap_ok = 1'b0;
    snap_top = '0;
    snap_bot = '0;
    for (int c = 0; c < 40 && sent < 8; c++) begin
      out_ready_i = !(c >= 5 && c < 8);
      in_valid_i  = 1'b1;
      data_top_i  = W'($urandom_range(0, 7680));
      data_bot_i  = W'($urandom_range(0, 7680));
      twiddle_i   = W'($urandom_range(0, 7680));
      scale_i     = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!out_ready_i && out_valid_o) begin
        check("stall_in_ready", in_ready_o, 0);
        if (snap_ok) begin
          check("stall_frozen_top", intt_top_o, snap_top);
          check("stall_frozen_bot", intt_bot_o, snap_bot);
        end
        snap_top = intt_top_o;
        snap_bot = intt_bot_o;
        snap_ok  = 1'b1;
      end
      if (in_ready_o) sent++;
      @(posedge clk);
      #2;
    end
    check("stall_stream_sent", sent, 8);
    out_ready_i = 1'b1;
    drain();

    // Asynchronous reset with one result on the outputs and more beats in flight.
    for (int i = 0; i < 5; i++) send(100 + i, 7 * i, 3 + i, 1'b0);
    in_valid_i = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid_o, 0);
    check("midrst_top", intt_top_o, 0);
    check("midrst_bot", intt_bot_o, 0);
    check("midrst_in_ready", in_ready_o, 1);
    exp_q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    send(5, 2, 3, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
